seq_rshift: RTL
===============

SEQ_RSHIFT -- requirements
Module: seq_rshift

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64: data width in bits, a power of two of at least 8.
REQ-002 The module SHALL have parameter STEP, default 8: maximum bit positions shifted per cycle, a power of two of at most WIDTH.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts a request.
REQ-007 The module SHALL have port in_data, input, WIDTH bits: the operand.
REQ-008 The module SHALL have port in_amt, input, $clog2(WIDTH)+1 bits: the unsigned right-shift amount.
REQ-009 The module SHALL have port in_mode, input, 2 bits: fill mode; 00 = zero fill, 01 = ones fill, 10 = arithmetic (replicate operand MSB), 11 = rotate.
REQ-010 The module SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The module SHALL have port out_data, output, WIDTH bits: the shifted result.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 A request is accepted when in_valid and in_ready are both 1 on a clock edge; at that edge the block SHALL capture in_data, in_mode, the fill bit and the remaining count rem.
REQ-015 The fill bit SHALL be 0 for mode 00, 1 for mode 01 and in_data[WIDTH-1] for mode 10, captured at acceptance and not re-sampled while shifting.
REQ-016 For modes 00, 01 and 10, rem SHALL be min(in_amt, WIDTH); for mode 11, rem SHALL be in_amt mod WIDTH.
REQ-017 On acceptance the FSM SHALL go to DONE if rem is 0, else to SHIFT.
REQ-018 In SHIFT, each cycle SHALL shift the working register right by k = min(rem, STEP) and set rem = rem - k.
REQ-019 In SHIFT, vacated MSBs SHALL take the fill bit in modes 00, 01 and 10, and the bits shifted out of the LSB end in mode 11.
REQ-020 When rem reaches 0, the FSM SHALL go to DONE on that same edge.
REQ-021 Latency: with acceptance at edge N, out_valid SHALL rise after edge N+1+ceil(rem/STEP)-1, i.e. after ceil(rem/STEP) shift cycles, or immediately after edge N when rem = 0.
REQ-022 In DONE, out_data SHALL equal the final working register and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 In DONE, out_valid && out_ready at an edge SHALL return the FSM to IDLE; a new request SHALL NOT be accepted on that same edge, since in_ready=0 during DONE.
REQ-024 in_data, in_amt and in_mode changes outside the accepting edge SHALL have no effect on a request in flight.
REQ-025 out_data SHALL be a registered output, never a combinational function of the inputs.
REQ-026 Results SHALL be bit-exact with the combinational reference: zero fill = in_data >> amt; ones fill = ~(~in_data >> amt); arithmetic = $signed(in_data) >>> amt; rotate = rotate-right by amt mod WIDTH.

Reset
REQ-027 While rst=1, asynchronously: the FSM SHALL be IDLE, in_ready=1, out_valid=0, out_data=0 and rem=0.
REQ-028 Reset asserted mid-SHIFT or mid-DONE SHALL discard the request in flight, with no out_valid pulse after release.
REQ-029 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-030 The bench SHALL cover zero fill: in_data=64'hFFFF_FFFF_FFFF_FF00, amt=8, mode=00, accepted at edge N -> out_data=64'h00FF_FFFF_FFFF_FFFF, out_valid high after edge N+1.
REQ-031 The bench SHALL cover ones and arithmetic fill:
- in_data=0, amt=8, mode=01 -> 64'hFF00_0000_0000_0000.
- in_data=64'h8000_0000_0000_0000, amt=63, mode=10 -> 64'hFFFF_FFFF_FFFF_FFFF after 8 shift cycles.
REQ-032 The bench SHALL cover saturation and rotate:
- amt=100, mode=00, any data -> 0 after 8 shift cycles.
- in_data=64'h0000_0000_0000_00F0, amt=68, mode=11 -> 64'h0000_0000_0000_000F after 1 shift cycle.
REQ-033 The bench SHALL cover zero amount: amt=0, mode=01, in_data=64'h1234_5678_9ABC_DEF0 -> the same value, out_valid high immediately after the accepting edge.
REQ-034 The bench SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0; then out_ready=1 -> return to IDLE, in_ready=1 on the following cycle.
REQ-035 The bench SHALL cover reset mid-operation: rst pulsed during SHIFT of an amt=40 request -> out_valid=0 and in_ready=1 immediately; no result is ever emitted for that request.

Source files
------------

// File: rtl/seq_rshift.sv
// seq_rshift: multi-cycle right shifter, at most STEP bit positions per cycle.
// Fill modes: zero, ones, arithmetic and rotate; valid/ready on both sides.
module seq_rshift #(
   parameter int WIDTH = 64,
   parameter int STEP  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [$clog2(WIDTH):0]     in_amt,
   input  logic [1:0]                 in_mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data
);

   localparam int AW = $clog2(WIDTH) + 1;
   localparam int LW = $clog2(WIDTH);
   localparam logic [AW-1:0] STEP_W  = AW'(STEP);
   localparam logic [AW-1:0] WIDTH_W = AW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_n;

   logic [WIDTH-1:0] work;
   logic [AW-1:0]    rem;
   logic             fill;
   logic             rot;

   logic             accept;
   logic [AW-1:0]    rem_init;
   logic             fill_init;
   logic [AW-1:0]    k;
   logic [AW-1:0]    rem_nx;
   logic [WIDTH-1:0] shifted;

   assign accept   = in_valid && in_ready;
   assign out_data = work;

   // Initial count and fill bit derived from the request being offered.
   always_comb begin
      rem_init  = '0;
      fill_init = 1'b0;
      if (in_mode == 2'b11) begin
         rem_init = {1'b0, in_amt[LW-1:0]};
      end else if (in_amt > WIDTH_W) begin
         rem_init = WIDTH_W;
      end else begin
         rem_init = in_amt;
      end
      unique case (in_mode)
         2'b01:   fill_init = 1'b1;
         2'b10:   fill_init = in_data[WIDTH-1];
         default: fill_init = 1'b0;
      endcase
   end

   // One shift step: move by min(rem, STEP), feeding fill or wrapped bits.
   always_comb begin
      k       = (rem > STEP_W) ? STEP_W : rem;
      rem_nx  = rem - k;
      shifted = '0;
      if (rot) begin
         shifted = WIDTH'({work, work} >> k);
      end else begin
         shifted = WIDTH'({{WIDTH{fill}}, work} >> k);
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_n = (rem_init == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (rem_nx == '0) begin
               state_n = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath: capture on acceptance, then shift while in SHIFT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work <= '0;
         rem  <= '0;
         fill <= 1'b0;
         rot  <= 1'b0;
      end else if (accept) begin
         work <= in_data;
         rem  <= rem_init;
         fill <= fill_init;
         rot  <= (in_mode == 2'b11);
      end else if (state == SHIFT) begin
         work <= shifted;
         rem  <= rem_nx;
      end
   end

endmodule
